// File: rtl/peri_stream_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : peri_stream_responder
// Brief    : Memory-mapped peripheral that buffers words in a FIFO and streams
//            LEN of them out as a valid/ready job.
// Revision : 1.0
// ============================================================================
module peri_stream_responder #(
    parameter logic [15:0] BASE  = 16'h0100,
    parameter int          DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        peri_web,
    input  logic        peri_oeb,
    input  logic [15:0] peri_addr,
    input  logic [15:0] peri_datao,
    output logic [15:0] peri_datai,
    output logic        vec_valid,
    output logic [15:0] vec_data,
    output logic        vec_last,
    input  logic        vec_ready,
    output logic        busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [15:0]          r_len;
    logic [15:0]          r_remaining;
    logic                 r_done;
    logic                 r_ovf;
    logic [15:0]          r_datai;
    logic [15:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [15:0] w_offset;
    logic        w_in_win;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_len;
    logic        w_wr_status;
    logic        w_wr_data;
    logic        w_start;
    logic        w_abort;
    logic        w_flush;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_launch;
    logic        w_done_set;
    logic        w_done_clr;
    logic [3:0]  w_cnt4;
    logic [15:0] w_status;
    logic [15:0] w_rd_data;

    // Window check is done on the offset so a BASE near the top of the
    // address space cannot wrap around into low addresses.
    assign w_offset    = peri_addr - BASE;
    assign w_in_win    = (peri_addr >= BASE) && (w_offset < 16'd4);
    assign w_wr        = !peri_web && w_in_win;
    assign w_wr_ctrl   = w_wr && (w_offset[1:0] == 2'd0);
    assign w_wr_len    = w_wr && (w_offset[1:0] == 2'd1);
    assign w_wr_status = w_wr && (w_offset[1:0] == 2'd2);
    assign w_wr_data   = w_wr && (w_offset[1:0] == 2'd3);

    assign w_start = w_wr_ctrl && peri_datao[0];
    assign w_abort = w_wr_ctrl && peri_datao[1];
    assign w_flush = (w_wr_ctrl && peri_datao[2]) || w_abort;

    assign w_full = (r_count == c_FULL);
    assign w_pop  = vec_valid && vec_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push = w_wr_data && (!w_full || w_pop);
    assign w_drop = w_wr_data && w_full && !w_pop;

    assign w_launch   = (r_state == S_IDLE) && w_start && !w_abort && (r_len != 16'd0);
    assign w_done_set = ((r_state == S_IDLE) && w_start && !w_abort && (r_len == 16'd0))
                     || ((r_state == S_RUN) && w_pop && !w_abort && (r_remaining == 16'd1));
    assign w_done_clr = (w_wr_status && peri_datao[1]) || w_launch;

    assign w_cnt4   = 4'(r_count);
    assign w_status = {9'b0, w_cnt4, r_ovf, r_done, busy};

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_in_win) begin
            case (w_offset[1:0])
                2'd1:    w_rd_data = r_len;
                2'd2:    w_rd_data = w_status;
                default: w_rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= peri_datao;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= 16'h0000;
            r_remaining <= 16'h0000;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_datai     <= 16'h0000;
        end else begin
            // Registers still hold pre-write values here, giving read-before-write.
            if (!peri_oeb) begin
                r_datai <= w_rd_data;
            end
            if (w_wr_len) begin
                r_len <= peri_datao;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && peri_datao[2]) begin
                r_ovf <= 1'b0;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_remaining <= r_len;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_pop) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == S_RUN);
    assign vec_valid  = busy && (r_count != '0);
    assign vec_data   = vec_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign vec_last   = vec_valid && (r_remaining == 16'd1);
    assign peri_datai = r_datai;

endmodule
`default_nettype wire

// File: tb/tb_peri_stream_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_peri_stream_responder
// Brief    : Scoreboard bench for peri_stream_responder bus and stream paths.
// Revision : 1.0
// ============================================================================
module tb_peri_stream_responder;

    localparam logic [15:0] c_CTRL   = 16'h0100;
    localparam logic [15:0] c_LEN    = 16'h0101;
    localparam logic [15:0] c_STATUS = 16'h0102;
    localparam logic [15:0] c_DATA   = 16'h0103;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        peri_web = 1'b1;
    logic        peri_oeb = 1'b1;
    logic [15:0] peri_addr = 16'h0000;
    logic [15:0] peri_datao = 16'h0000;
    logic [15:0] peri_datai;
    logic        vec_valid;
    logic [15:0] vec_data;
    logic        vec_last;
    logic        vec_ready = 1'b0;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    int          m_rem = 0;
    logic [15:0] mon_exp;

    peri_stream_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .peri_web   (peri_web),
        .peri_oeb   (peri_oeb),
        .peri_addr  (peri_addr),
        .peri_datao (peri_datao),
        .peri_datai (peri_datai),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_last   (vec_last),
        .vec_ready  (vec_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Every handshake is checked against the scoreboard queue and job model.
    always @(negedge clk) begin
        if (vec_valid && vec_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got beat %h, required no beat", vec_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (vec_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL beat_data: got %h, required %h", vec_data, mon_exp);
                end
                n_vec++;
                if (vec_last !== (m_rem == 1)) begin
                    n_err++;
                    $display("FAIL beat_last: got %b, required %b", vec_last, (m_rem == 1));
                end
                m_rem--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        peri_addr  = a;
        peri_datao = d;
        peri_web   = 1'b0;
        tick();
        peri_web   = 1'b1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        peri_addr = a;
        peri_oeb  = 1'b0;
        tick();
        peri_oeb  = 1'b1;
        d         = peri_datai;
    endtask

    task automatic push(input logic [15:0] d, input bit accept);
        bus_wr(c_DATA, d);
        if (accept) exp_q.push_back(d);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        tick(); tick();
        if ({peri_datai, vec_data, vec_valid, vec_last, busy} !== 35'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h, required 0", {peri_datai, vec_data, vec_valid, vec_last, busy});
        end
        n_vec++;
        rst_n = 1'b1;
        tick();
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h, required 0000", rd); end
        n_vec++;
        bus_rd(c_LEN, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_len: got %h, required 0000", rd); end
        n_vec++;
    endtask

    task automatic test_basic();
        logic [15:0] rd;
        bus_wr(c_LEN, 16'd3);
        push(16'h00A1, 1'b1);
        push(16'h00A2, 1'b1);
        push(16'h00A3, 1'b1);
        vec_ready = 1'b1;
        m_rem = 3;
        bus_wr(c_CTRL, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (vec_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b, required 1", i, vec_valid); end
            n_vec++;
        end
        tick();
        if ({vec_valid, busy} !== 2'b00) begin n_err++; $display("FAIL basic_end: got valid,busy=%b, required 00", {vec_valid, busy}); end
        n_vec++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL basic_drain: got %0d left, required 0", exp_q.size()); end
        n_vec++;
        vec_ready = 1'b0;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0002) begin n_err++; $display("FAIL basic_status: got %h, required 0002", rd); end
        n_vec++;
    endtask

    task automatic test_overflow();
        logic [15:0] rd;
        bus_wr(c_STATUS, 16'h0006);
        for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i), i < 8);
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0044) begin n_err++; $display("FAIL ovf_status: got %h, required 0044", rd); end
        n_vec++;
        bus_wr(c_STATUS, 16'h0004);
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0040) begin n_err++; $display("FAIL ovf_w1c: got %h, required 0040", rd); end
        n_vec++;
        bus_wr(c_LEN, 16'd2);
        m_rem = 2;
        bus_wr(c_CTRL, 16'h0001);
        vec_ready = 1'b1;
        push(16'h2000, 1'b1);
        vec_ready = 1'b0;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0041) begin n_err++; $display("FAIL full_push_pop: got %h, required 0041", rd); end
        n_vec++;
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h003A) begin n_err++; $display("FAIL ovf_job_end: got %h, required 003a", rd); end
        n_vec++;
        bus_wr(c_CTRL, 16'h0004);
        exp_q.delete();
        bus_wr(c_STATUS, 16'h0002);
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL flush_status: got %h, required 0000", rd); end
        n_vec++;
    endtask

    task automatic test_stall();
        logic [15:0] rd;
        bus_wr(c_LEN, 16'd2);
        m_rem = 2;
        bus_wr(c_CTRL, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({vec_valid, busy} !== 2'b01) begin n_err++; $display("FAIL stall_empty[%0d]: got valid,busy=%b, required 01", i, {vec_valid, busy}); end
            n_vec++;
            @(posedge clk); #1;
        end
        push(16'h0055, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({vec_valid, vec_data} !== {1'b1, 16'h0055}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %b/%h, required 1/0055", i, vec_valid, vec_data);
            end
            n_vec++;
            @(posedge clk); #1;
        end
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        if ({vec_valid, busy} !== 2'b01) begin n_err++; $display("FAIL stall_wait2: got valid,busy=%b, required 01", {vec_valid, busy}); end
        n_vec++;
        push(16'h0066, 1'b1);
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        if ({vec_valid, busy} !== 2'b00) begin n_err++; $display("FAIL stall_end: got valid,busy=%b, required 00", {vec_valid, busy}); end
        n_vec++;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0002) begin n_err++; $display("FAIL stall_status: got %h, required 0002", rd); end
        n_vec++;
        bus_wr(c_STATUS, 16'h0002);
    endtask

    task automatic test_zero_len();
        logic [15:0] rd;
        bus_wr(c_LEN, 16'd0);
        bus_wr(c_CTRL, 16'h0001);
        if ({vec_valid, busy} !== 2'b00) begin n_err++; $display("FAIL zlen_idle: got valid,busy=%b, required 00", {vec_valid, busy}); end
        n_vec++;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0002) begin n_err++; $display("FAIL zlen_done: got %h, required 0002", rd); end
        n_vec++;
        bus_wr(c_STATUS, 16'h0002);
    endtask

    task automatic test_abort();
        logic [15:0] rd;
        for (int i = 0; i < 4; i++) push(16'h0030 + 16'(i), 1'b1);
        bus_wr(c_LEN, 16'd4);
        m_rem = 4;
        bus_wr(c_CTRL, 16'h0001);
        vec_ready = 1'b1;
        tick(); tick();
        vec_ready = 1'b0;
        bus_wr(c_CTRL, 16'h0002);
        exp_q.delete();
        m_rem = 0;
        if ({vec_valid, busy} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got valid,busy=%b, required 00", {vec_valid, busy}); end
        n_vec++;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL abort_status: got %h, required 0000", rd); end
        n_vec++;
        bus_wr(16'h00FF, 16'hFFFF);
        bus_wr(16'h0104, 16'h0007);
        bus_rd(16'h00FF, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL below_base_rd: got %h, required 0000", rd); end
        n_vec++;
        bus_rd(16'h0104, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL above_win_rd: got %h, required 0000", rd); end
        n_vec++;
        bus_rd(c_LEN, rd);
        if (rd !== 16'd4) begin n_err++; $display("FAIL outside_wr_len: got %h, required 0004", rd); end
        n_vec++;
        bus_rd(c_CTRL, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL ctrl_rd: got %h, required 0000", rd); end
        n_vec++;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL outside_wr_status: got %h, required 0000", rd); end
        n_vec++;
        peri_addr = c_LEN; peri_datao = 16'd9; peri_web = 1'b0; peri_oeb = 1'b0;
        tick();
        peri_web = 1'b1; peri_oeb = 1'b1;
        if (peri_datai !== 16'd4) begin n_err++; $display("FAIL rd_before_wr: got %h, required 0004", peri_datai); end
        n_vec++;
        bus_rd(c_LEN, rd);
        if (rd !== 16'd9) begin n_err++; $display("FAIL rw_len_after: got %h, required 0009", rd); end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        for (int i = 0; i < 3; i++) push(16'h00C1 + 16'(i), 1'b1);
        bus_wr(c_LEN, 16'd3);
        m_rem = 3;
        bus_wr(c_CTRL, 16'h0001);
        bus_rd(c_LEN, rd);
        if ({vec_valid, busy} !== 2'b11) begin n_err++; $display("FAIL mid_running: got valid,busy=%b, required 11", {vec_valid, busy}); end
        n_vec++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({peri_datai, vec_data, vec_valid, vec_last, busy} !== 35'd0) begin
            n_err++; $display("FAIL async_reset: got %h, required 0", {peri_datai, vec_data, vec_valid, vec_last, busy});
        end
        n_vec++;
        exp_q.delete();
        m_rem = 0;
        #2;
        rst_n = 1'b1;
        tick();
        vec_ready = 1'b1;
        repeat (4) tick();
        if ({vec_valid, busy} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle: got valid,busy=%b, required 00", {vec_valid, busy}); end
        n_vec++;
        vec_ready = 1'b0;
        bus_rd(c_STATUS, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL post_reset_status: got %h, required 0000", rd); end
        n_vec++;
        bus_rd(c_LEN, rd);
        if (rd !== 16'h0000) begin n_err++; $display("FAIL post_reset_len: got %h, required 0000", rd); end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_zero_len();
        test_abort();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peri_stream_responder.md
PERI_STREAM_RESPONDER -- requirements
Module: peri_stream_responder

Interface
REQ-001 SHALL have parameter BASE, default 16'h0100, peripheral window base address.
REQ-002 SHALL have parameter DEPTH, default 8, data FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port peri_web  input  1  active-low write strobe from the pipeline.
REQ-006 SHALL have port peri_oeb  input  1  active-low read strobe.
REQ-007 SHALL have port peri_addr  input  16  register address for read or write.
REQ-008 SHALL have port peri_datao  input  16  write data from the pipeline.
REQ-009 SHALL have port peri_datai  output  16  registered read data.
REQ-010 SHALL have port vec_valid  output  1  stream beat valid.
REQ-011 SHALL have port vec_data  output  16  stream beat payload.
REQ-012 SHALL have port vec_last  output  1  marks the final beat of a job.
REQ-013 SHALL have port vec_ready  input  1  downstream accepts a beat.
REQ-014 SHALL have port busy  output  1  high while the FSM is in RUN.

Function
REQ-015 SHALL decode BASE+0 CTRL (W: bit0 start, bit1 abort, bit2 flush; reads 0), BASE+1 LEN (R/W, 16 bit), BASE+2 STATUS (R; W1C bits 1,2), BASE+3 DATA (W: FIFO push; reads 0).
REQ-016 SHALL ignore writes, and return 16'h0000 on reads, for any address outside BASE..BASE+3, including all addresses below BASE.
REQ-017 SHALL perform a write on any cycle with peri_web==0; CTRL bits act as one-cycle pulses and are not stored.
REQ-018 SHALL update peri_datai one cycle after a cycle with peri_oeb==0 and hold it otherwise; when read and write occur in the same cycle, the read SHALL return the pre-write value.
REQ-019 SHALL format STATUS as {9'b0, count[3:0], ovf, done, busy}, count = FIFO occupancy 0..DEPTH.
REQ-020 SHALL push peri_datao into the FIFO on a DATA write when not full; a push when full SHALL drop the data and set sticky ovf.
REQ-021 SHALL pop the FIFO head on each cycle with vec_valid && vec_ready; a push and pop in the same cycle SHALL leave count unchanged, including at full (push accepted, no ovf).
REQ-022 SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-023 IDLE: start with LEN!=0 SHALL load remaining=LEN, clear done, go RUN next cycle; start with LEN==0 SHALL set done and stay IDLE.
REQ-024 RUN: vec_valid = (count!=0), combinational from FIFO state; vec_data = FIFO head; vec_last = vec_valid && remaining==1.
REQ-025 RUN: each handshake SHALL decrement remaining; a handshake with remaining==1 SHALL set done and return to IDLE the next cycle.
REQ-026 vec_valid and vec_data SHALL stay stable while vec_valid && !vec_ready, except on abort.
REQ-027 RUN with an empty FIFO SHALL wait with vec_valid low; there is no timeout.
REQ-028 start while in RUN SHALL be ignored; LEN writes during RUN SHALL update LEN but not remaining.
REQ-029 abort SHALL force IDLE next cycle, flush the FIFO, and leave done unchanged; a handshake in the abort cycle still pops.
REQ-030 flush SHALL empty the FIFO in any state; flush and a DATA push in the same cycle SHALL leave the FIFO empty.
REQ-031 vec_valid, vec_last SHALL be 0 in IDLE; busy = (state==RUN).
REQ-032 W1C: writing 1 to STATUS bit1/bit2 SHALL clear done/ovf; a set event in the same cycle SHALL win over the clear.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, FIFO empty, LEN=0, remaining=0, done=0, ovf=0, peri_datai=0, vec_valid=0, vec_last=0, busy=0, independent of clk.
REQ-034 reset asserted mid-job SHALL discard the job and all FIFO contents; no beat SHALL appear after release until a new start.

Verification
REQ-035 Write LEN=3, push 16'hA1,16'hA2,16'hA3, start, vec_ready=1 -> beats A1,A2,A3 on consecutive cycles, vec_last only on A3, STATUS reads 16'h0002 afterwards.
REQ-036 Push 9 words with DEPTH=8, no job running -> STATUS = 16'h0044 (count 8, ovf); write STATUS 16'h0004 -> 16'h0040.
REQ-037 LEN=2, start with empty FIFO, push 16'h0055 after 5 cycles, vec_ready toggling 0/1 -> beat held stable while stalled; job completes only after second push.
REQ-038 LEN=0, start -> no vec_valid, busy stays 0, done=1 next cycle.
REQ-039 LEN=4, two beats accepted, then abort -> busy=0 next cycle, count=0, done=0; write to address 16'h00FF -> no register changes, read returns 0.
REQ-040 Assert rst_n=0 mid-job between clock edges -> all outputs zero before the next rising edge; after release STATUS reads 16'h0000.
